// File: rtl/fetch_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_pkg : state encoding and AXI/line constants for the fetch front end
// Rev 1.0
// ---------------------------------------------------------------------------
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      AR    = 2'd1,
      DATA  = 2'd2,
      DRAIN = 2'd3
   } fetch_state_e;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [2:0] AXI_SIZE_8B    = 3'd3;
   localparam logic [7:0] AXI_LEN_LINE   = 8'd7;

   localparam int LINE_BYTES     = 64;
   localparam int INSTS_PER_LINE = 16;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_line_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_line_buffer : 8 x 64-bit beat store with per-beat valid/fault bits
// and a 16-slot 32-bit instruction read mux.  Rev 1.0
// ---------------------------------------------------------------------------
module fetch_line_buffer
   import fetch_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear_i,
   input  logic        wr_en_i,
   input  logic [2:0]  wr_idx_i,
   input  logic [63:0] wr_data_i,
   input  logic        wr_fault_i,
   input  logic [3:0]  rd_slot_i,
   output logic        rd_valid_o,
   output logic [31:0] rd_inst_o,
   output logic        rd_fault_o
);

   logic [63:0] beat_q [0:7];
   logic [7:0]  beat_valid_q, beat_valid_d;
   logic [7:0]  fault_q, fault_d;
   logic [63:0] w_rd_beat;

   always_comb begin
      beat_valid_d = beat_valid_q;
      fault_d      = fault_q;
      if (clear_i) begin
         beat_valid_d = '0;
      end else if (wr_en_i) begin
         beat_valid_d[wr_idx_i] = 1'b1;
         fault_d[wr_idx_i]      = wr_fault_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         beat_valid_q <= '0;
         fault_q      <= '0;
      end else begin
         beat_valid_q <= beat_valid_d;
         fault_q      <= fault_d;
      end
   end

   // Payload needs no reset: it is only observed through beat_valid_q.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         beat_q[wr_idx_i] <= wr_data_i;
      end
   end

   assign w_rd_beat  = beat_q[rd_slot_i[3:1]];
   assign rd_valid_o = beat_valid_q[rd_slot_i[3:1]];
   assign rd_fault_o = fault_q[rd_slot_i[3:1]];
   assign rd_inst_o  = rd_slot_i[0] ? w_rd_beat[63:32] : w_rd_beat[31:0];

endmodule : fetch_line_buffer
`default_nettype wire

// File: rtl/fetch_line_streamer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_line_streamer : fetches 64-byte lines as 8-beat AXI INCR bursts and
// streams PC-tagged 32-bit instructions to decode; redirects drain and refetch.
// Rev 1.0
// ---------------------------------------------------------------------------
module fetch_line_streamer
   import fetch_pkg::*;
#(
   parameter int                  ID_WIDTH   = 13,
   parameter int                  ADDR_WIDTH = 64,
   parameter int                  DATA_WIDTH = 64,
   parameter int                  LINE_BEATS = 8,
   parameter logic [ID_WIDTH-1:0] FETCH_ARID = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] start_pc,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic [ID_WIDTH-1:0]   m_axi_arid,
   output logic [ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [7:0]            m_axi_arlen,
   output logic [2:0]            m_axi_arsize,
   output logic [1:0]            m_axi_arburst,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   input  logic [DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rlast,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready,
   output logic                  inst_valid,
   input  logic                  inst_ready,
   output logic [31:0]           inst,
   output logic [ADDR_WIDTH-1:0] inst_pc,
   output logic                  inst_fault
);

   localparam int               OFS_W      = $clog2(LINE_BYTES);
   localparam int               LINE_W     = ADDR_WIDTH - OFS_W;
   localparam logic [LINE_W-1:0] LINE_INC  = LINE_W'(1);
   localparam logic [3:0]       BEATS_FULL = 4'(LINE_BEATS);
   localparam logic [3:0]       BEATS_LAST = 4'(LINE_BEATS - 1);
   localparam logic [3:0]       SLOT_LAST  = 4'(INSTS_PER_LINE - 1);

   fetch_state_e          state_q, state_d;
   logic [ADDR_WIDTH-1:2] pc_q, pc_d;
   logic [LINE_W-1:0]     line_q, line_d;
   logic [3:0]            idx_q, idx_d;
   logic [3:0]            beat_cnt_q, beat_cnt_d;
   logic                  stale_q, stale_d;

   logic                  w_buf_clear;
   logic                  w_buf_wr;
   logic                  w_burst_done;
   logic                  w_inst_fire;
   logic                  w_slot_valid;
   logic                  w_slot_fault;
   logic [31:0]           w_slot_inst;
   logic                  w_unused;

   // PC bits [1:0] never matter: instructions are word aligned.
   assign w_unused = ^{start_pc[1:0], redirect_pc[1:0]};

   assign w_buf_wr     = (state_q == DATA) && m_axi_rvalid && (beat_cnt_q != BEATS_FULL);
   assign w_burst_done = (beat_cnt_q == BEATS_FULL) ||
                         (m_axi_rvalid && (beat_cnt_q == BEATS_LAST));
   assign w_inst_fire  = inst_valid && inst_ready;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      line_d      = line_q;
      idx_d       = idx_q;
      beat_cnt_d  = beat_cnt_q;
      stale_d     = stale_q;
      w_buf_clear = 1'b0;

      case (state_q)
         IDLE: begin
            state_d = AR;
         end
         AR: begin
            // A redirect seen while the address was pending poisons that burst.
            if (m_axi_arready) begin
               beat_cnt_d  = '0;
               w_buf_clear = 1'b1;
               idx_d       = pc_q[OFS_W-1:2];
               stale_d     = 1'b0;
               state_d     = (stale_q || redirect_valid) ? DRAIN : DATA;
            end else if (redirect_valid) begin
               stale_d = 1'b1;
            end
         end
         DATA: begin
            if (w_buf_wr) begin
               beat_cnt_d = beat_cnt_q + 4'd1;
            end
            if (redirect_valid) begin
               state_d = w_burst_done ? AR : DRAIN;
            end else if (w_inst_fire) begin
               idx_d = idx_q + 4'd1;
               if (idx_q == SLOT_LAST) begin
                  pc_d    = {pc_q[ADDR_WIDTH-1:OFS_W] + LINE_INC, 4'b0000};
                  state_d = AR;
               end
            end
         end
         DRAIN: begin
            if (m_axi_rvalid && m_axi_rlast) begin
               state_d = AR;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (redirect_valid) begin
         pc_d = redirect_pc[ADDR_WIDTH-1:2];
      end

      // The request address is captured once on entry and then frozen.
      if ((state_d == AR) && (state_q != AR)) begin
         line_d = pc_d[ADDR_WIDTH-1:OFS_W];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         pc_q       <= start_pc[ADDR_WIDTH-1:2];
         line_q     <= start_pc[ADDR_WIDTH-1:OFS_W];
         idx_q      <= '0;
         beat_cnt_q <= '0;
         stale_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         line_q     <= line_d;
         idx_q      <= idx_d;
         beat_cnt_q <= beat_cnt_d;
         stale_q    <= stale_d;
      end
   end

   fetch_line_buffer u_line_buffer (
      .clk        (clk),
      .reset      (reset),
      .clear_i    (w_buf_clear),
      .wr_en_i    (w_buf_wr),
      .wr_idx_i   (beat_cnt_q[2:0]),
      .wr_data_i  (m_axi_rdata[63:0]),
      .wr_fault_i (m_axi_rresp != 2'b00),
      .rd_slot_i  (idx_q),
      .rd_valid_o (w_slot_valid),
      .rd_inst_o  (w_slot_inst),
      .rd_fault_o (w_slot_fault)
   );

   assign m_axi_arid    = FETCH_ARID;
   assign m_axi_araddr  = {line_q, {OFS_W{1'b0}}};
   assign m_axi_arlen   = AXI_LEN_LINE;
   assign m_axi_arsize  = AXI_SIZE_8B;
   assign m_axi_arburst = AXI_BURST_INCR;
   assign m_axi_arvalid = (state_q == AR);
   assign m_axi_rready  = (state_q == DATA) || (state_q == DRAIN);

   assign inst_valid = (state_q == DATA) && w_slot_valid;
   assign inst       = w_slot_inst;
   assign inst_fault = w_slot_fault;
   assign inst_pc    = {pc_q[ADDR_WIDTH-1:OFS_W], idx_q, 2'b00};

endmodule : fetch_line_streamer
`default_nettype wire
